mac_tx_arbiter: RTL and testbench

MAC_TX_ARBITER -- requirements
Module: mac_tx_arbiter

---
 rtl/mac_tx_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mac_tx_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_tx_arbiter.sv
// rtl/mac_tx_arbiter.sv - two-source round-robin frame arbiter in front of a byte-wide MAC
// Optional feature: define TX_ARB_WATCHDOG_EN to abort frames whose owner stalls for WDOG_CYCLES.
module mac_tx_arbiter #(
  parameter int GAP_CYCLES  = 4,
  parameter int WDOG_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s0_req,
  input  logic [7:0] s0_tx_data,
  input  logic       s0_tx_sop,
  input  logic       s0_tx_eop,
  input  logic       s0_tx_err,
  input  logic       s0_tx_wren,
  output logic       s0_tx_rdy,
  input  logic       s1_req,
  input  logic [7:0] s1_tx_data,
  input  logic       s1_tx_sop,
  input  logic       s1_tx_eop,
  input  logic       s1_tx_err,
  input  logic       s1_tx_wren,
  output logic       s1_tx_rdy,
  output logic       tx_clk,
  output logic [7:0] tx_data,
  output logic       tx_sop,
  output logic       tx_eop,
  output logic       tx_err,
  output logic       tx_wren,
  input  logic       tx_rdy,
  output logic [1:0] grant,
  output logic       wdog_abort
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OWN0,
    ST_OWN1,
    ST_GAP
`ifdef TX_ARB_WATCHDOG_EN
    , ST_ABORT
`endif
  } state_t;

  // Last gap count value; unused when GAP_CYCLES is 0 because GAP is then skipped.
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam state_t     REL_STATE = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

  if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
    $error("mac_tx_arbiter: GAP_CYCLES must be 0..255");
  end
  if (WDOG_CYCLES < 1 || WDOG_CYCLES > 65535) begin : g_bad_wdog
    $error("mac_tx_arbiter: WDOG_CYCLES must be 1..65535");
  end

  state_t     state_q;
  logic       rr_q;        // source granted most recently
  logic [7:0] gap_q;
  logic [1:0] grant_q;
  logic       own_acc;     // owner beat accepted this cycle
  logic       own_id;      // which source owns the MAC (valid in OWN states)

  assign tx_clk = clk;
  assign grant  = grant_q;
  assign own_id = (state_q == ST_OWN1);

  // Route the owner's strobes to the MAC, MAC ready back to the owner only.
  always_comb begin
    tx_data   = 8'h00;
    tx_sop    = 1'b0;
    tx_eop    = 1'b0;
    tx_err    = 1'b0;
    tx_wren   = 1'b0;
    s0_tx_rdy = 1'b0;
    s1_tx_rdy = 1'b0;
    own_acc   = 1'b0;
    case (state_q)
      ST_OWN0: begin
        tx_data   = s0_tx_data;
        tx_sop    = s0_tx_sop;
        tx_eop    = s0_tx_eop;
        tx_err    = s0_tx_err;
        tx_wren   = s0_tx_wren;
        s0_tx_rdy = tx_rdy;
        own_acc   = tx_rdy & s0_tx_wren;
      end
      ST_OWN1: begin
        tx_data   = s1_tx_data;
        tx_sop    = s1_tx_sop;
        tx_eop    = s1_tx_eop;
        tx_err    = s1_tx_err;
        tx_wren   = s1_tx_wren;
        s1_tx_rdy = tx_rdy;
        own_acc   = tx_rdy & s1_tx_wren;
      end
`ifdef TX_ARB_WATCHDOG_EN
      ST_ABORT: begin
        tx_wren = 1'b1;
        tx_eop  = 1'b1;
        tx_err  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

`ifdef TX_ARB_WATCHDOG_EN
  localparam logic [15:0] WDOG_LAST = 16'(WDOG_CYCLES - 1);
  logic [15:0] wdog_q;
  logic        wdog_abort_q;
  assign wdog_abort = wdog_abort_q;
`else
  assign wdog_abort = 1'b0;
`endif

  // Arbitration FSM: ownership, round-robin pointer, gap and stall counters, registered grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rr_q         <= 1'b1;
      gap_q        <= 8'd0;
      grant_q      <= 2'b00;
`ifdef TX_ARB_WATCHDOG_EN
      wdog_q       <= 16'd0;
      wdog_abort_q <= 1'b0;
`endif
    end else begin
`ifdef TX_ARB_WATCHDOG_EN
      wdog_abort_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (s0_req && (!s1_req || rr_q)) begin
            state_q <= ST_OWN0;
            grant_q <= 2'b01;
          end else if (s1_req) begin
            state_q <= ST_OWN1;
            grant_q <= 2'b10;
          end
        end
        ST_OWN0, ST_OWN1: begin
          if (own_acc && tx_eop) begin
            rr_q    <= own_id;
            state_q <= REL_STATE;
            grant_q <= 2'b00;
            gap_q   <= 8'd0;
`ifdef TX_ARB_WATCHDOG_EN
            wdog_q  <= 16'd0;
          end else if (own_acc) begin
            wdog_q  <= 16'd0;
          end else if (wdog_q == WDOG_LAST) begin
            rr_q         <= own_id;
            state_q      <= ST_ABORT;
            grant_q      <= 2'b00;
            wdog_q       <= 16'd0;
            wdog_abort_q <= 1'b1;
          end else begin
            wdog_q  <= wdog_q + 16'd1;
`endif
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= ST_IDLE;
            gap_q   <= 8'd0;
          end else begin
            gap_q   <= gap_q + 8'd1;
          end
        end
`ifdef TX_ARB_WATCHDOG_EN
        ST_ABORT: begin
          if (tx_rdy) begin
            state_q <= REL_STATE;
            gap_q   <= 8'd0;
          end else begin
            wdog_abort_q <= 1'b1;
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// tb/tb_mac_tx_arbiter.sv - directed self-checking bench for mac_tx_arbiter
module tb_mac_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       s0_req, s0_tx_sop, s0_tx_eop, s0_tx_err, s0_tx_wren;
  logic       s1_req, s1_tx_sop, s1_tx_eop, s1_tx_err, s1_tx_wren;
  logic [7:0] s0_tx_data, s1_tx_data;
  logic       tx_rdy;

  logic       s0_tx_rdy, s1_tx_rdy, tx_clk, tx_sop, tx_eop, tx_err, tx_wren, wdog_abort;
  logic [7:0] tx_data;
  logic [1:0] grant;

  logic       z_s0_tx_rdy, z_s1_tx_rdy, z_tx_clk, z_tx_sop, z_tx_eop, z_tx_err, z_tx_wren, z_wdog_abort;
  logic [7:0] z_tx_data;
  logic [1:0] z_grant;

  int total = 0;
  int bad   = 0;

  mac_tx_arbiter #(.GAP_CYCLES(4), .WDOG_CYCLES(8)) u_dut (
    .clk(clk), .rst(rst),
    .s0_req(s0_req), .s0_tx_data(s0_tx_data), .s0_tx_sop(s0_tx_sop), .s0_tx_eop(s0_tx_eop),
    .s0_tx_err(s0_tx_err), .s0_tx_wren(s0_tx_wren), .s0_tx_rdy(s0_tx_rdy),
    .s1_req(s1_req), .s1_tx_data(s1_tx_data), .s1_tx_sop(s1_tx_sop), .s1_tx_eop(s1_tx_eop),
    .s1_tx_err(s1_tx_err), .s1_tx_wren(s1_tx_wren), .s1_tx_rdy(s1_tx_rdy),
    .tx_clk(tx_clk), .tx_data(tx_data), .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_err(tx_err),
    .tx_wren(tx_wren), .tx_rdy(tx_rdy), .grant(grant), .wdog_abort(wdog_abort)
  );

  mac_tx_arbiter #(.GAP_CYCLES(0), .WDOG_CYCLES(255)) u_dut0 (
    .clk(clk), .rst(rst),
    .s0_req(s0_req), .s0_tx_data(s0_tx_data), .s0_tx_sop(s0_tx_sop), .s0_tx_eop(s0_tx_eop),
    .s0_tx_err(s0_tx_err), .s0_tx_wren(s0_tx_wren), .s0_tx_rdy(z_s0_tx_rdy),
    .s1_req(s1_req), .s1_tx_data(s1_tx_data), .s1_tx_sop(s1_tx_sop), .s1_tx_eop(s1_tx_eop),
    .s1_tx_err(s1_tx_err), .s1_tx_wren(s1_tx_wren), .s1_tx_rdy(z_s1_tx_rdy),
    .tx_clk(z_tx_clk), .tx_data(z_tx_data), .tx_sop(z_tx_sop), .tx_eop(z_tx_eop), .tx_err(z_tx_err),
    .tx_wren(z_tx_wren), .tx_rdy(tx_rdy), .grant(z_grant), .wdog_abort(z_wdog_abort)
  );

  task automatic idle_inputs();
    s0_req = 0; s0_tx_data = 8'h00; s0_tx_sop = 0; s0_tx_eop = 0; s0_tx_err = 0; s0_tx_wren = 0;
    s1_req = 0; s1_tx_data = 8'h00; s1_tx_sop = 0; s1_tx_eop = 0; s1_tx_err = 0; s1_tx_wren = 0;
    tx_rdy = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    s0_req = 1; s0_tx_wren = 1; s0_tx_data = 8'hFF; s0_tx_sop = 1;
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b want=00", grant); end
    total++; if (tx_wren !== 1'b0) begin bad++; $display("FAIL reset_wren got=%b want=0", tx_wren); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", tx_data); end
    total++; if (s0_tx_rdy !== 1'b0) begin bad++; $display("FAIL reset_s0_rdy got=%b want=0", s0_tx_rdy); end
    total++; if (wdog_abort !== 1'b0) begin bad++; $display("FAIL reset_wdog got=%b want=0", wdog_abort); end
    total++; if (tx_clk !== clk) begin bad++; $display("FAIL reset_txclk got=%b want=%b", tx_clk, clk); end
    rst = 0;
  endtask

  task automatic test_tie();
    do_reset();
    s0_req = 1; s1_req = 1;
    s0_tx_data = 8'hA0; s0_tx_sop = 1; s0_tx_wren = 1;
    s1_tx_data = 8'hB0; s1_tx_sop = 1; s1_tx_eop = 1; s1_tx_wren = 1;
    @(negedge clk); #1;
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL tie_grant got=%b want=01", grant); end
    total++; if (tx_data !== 8'hA0 || tx_sop !== 1'b1) begin bad++; $display("FAIL tie_first got=%h/%b want=a0/1", tx_data, tx_sop); end
    total++; if (s0_tx_rdy !== 1'b1 || s1_tx_rdy !== 1'b0) begin bad++; $display("FAIL tie_rdy got=%b%b want=10", s0_tx_rdy, s1_tx_rdy); end
    @(negedge clk);
    s0_tx_data = 8'hA1; s0_tx_sop = 0; s0_tx_eop = 1;
    #1;
    total++; if (grant !== 2'b01 || tx_eop !== 1'b1 || tx_data !== 8'hA1) begin bad++; $display("FAIL tie_eop got=%b/%b/%h want=01/1/a1", grant, tx_eop, tx_data); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s0_req = 0; s0_tx_wren = 0; s0_tx_eop = 0;
      #1;
      total++; if (grant !== 2'b00 || tx_wren !== 1'b0) begin bad++; $display("FAIL tie_gap%0d got=%b/%b want=00/0", i, grant, tx_wren); end
    end
    @(negedge clk); #1;
    total++; if (grant !== 2'b10) begin bad++; $display("FAIL tie_second got=%b want=10", grant); end
    total++; if (tx_data !== 8'hB0 || s1_tx_rdy !== 1'b1 || s0_tx_rdy !== 1'b0) begin bad++; $display("FAIL tie_second_mux got=%h/%b%b want=b0/01", tx_data, s0_tx_rdy, s1_tx_rdy); end
  endtask

  task automatic test_stream64();
    int idx;
    int extra;
    logic rdy_t;
    idx = 0; extra = 0; rdy_t = 0;
    do_reset();
    s1_req = 1;
    for (int cyc = 0; cyc < 400 && idx < 64; cyc++) begin
      @(negedge clk);
      rdy_t = ~rdy_t;
      tx_rdy = rdy_t;
      s1_tx_data = 8'(idx + 16); s1_tx_sop = (idx == 0); s1_tx_eop = (idx == 63); s1_tx_wren = 1;
      #1;
      if (tx_wren && tx_rdy) begin
        total++;
        if (tx_data !== 8'(idx + 16) || tx_sop !== (idx == 0) || tx_eop !== (idx == 63) || grant !== 2'b10) begin
          bad++; $display("FAIL stream_beat%0d got=%h/%b/%b/%b want=%h/%b/%b/10", idx, tx_data, tx_sop, tx_eop, grant, 8'(idx + 16), idx == 0, idx == 63);
        end
        idx++;
      end
    end
    total++; if (idx !== 64) begin bad++; $display("FAIL stream_count got=%0d want=64", idx); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s1_req = 0; s1_tx_wren = 0; s1_tx_eop = 0; tx_rdy = 1;
      #1;
      if (tx_wren) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL stream_extra got=%0d want=0", extra); end
  endtask

  task automatic test_drop_req();
    int idx;
    idx = 0;
    do_reset();
    s0_req = 1;
    for (int cyc = 0; cyc < 300 && idx < 100; cyc++) begin
      @(negedge clk);
      s0_tx_data = 8'(idx + 100); s0_tx_sop = (idx == 0); s0_tx_eop = (idx == 99); s0_tx_wren = 1;
      if (idx >= 10) s0_req = 0;
      #1;
      if (tx_wren && tx_rdy) begin
        total++;
        if (grant !== 2'b01 || tx_data !== 8'(idx + 100)) begin
          bad++; $display("FAIL drop_beat%0d got=%b/%h want=01/%h", idx, grant, tx_data, 8'(idx + 100));
        end
        idx++;
      end
    end
    total++; if (idx !== 100) begin bad++; $display("FAIL drop_count got=%0d want=100", idx); end
    @(negedge clk);
    s0_tx_wren = 0; s0_tx_eop = 0;
    #1;
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL drop_release got=%b want=00", grant); end
  endtask

  task automatic test_gap0();
    logic [1:0] exp_g [12];
    logic p0, p1;
    exp_g = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
    p0 = 0; p1 = 0;
    do_reset();
    s0_req = 1; s1_req = 1;
    for (int c = 0; c < 12; c++) begin
      if (c != 0) @(negedge clk);
      s0_tx_data = {7'h30, p0}; s0_tx_sop = ~p0; s0_tx_eop = p0; s0_tx_wren = 1;
      s1_tx_data = {7'h50, p1}; s1_tx_sop = ~p1; s1_tx_eop = p1; s1_tx_wren = 1;
      #1;
      total++;
      if (z_grant !== exp_g[c] || z_tx_wren !== (exp_g[c] != 2'b00) || z_tx_err !== 1'b0 || z_wdog_abort !== 1'b0) begin
        bad++; $display("FAIL gap0_cyc%0d got=%b/%b want=%b/%b", c, z_grant, z_tx_wren, exp_g[c], exp_g[c] != 2'b00);
      end
      if (z_s0_tx_rdy && s0_tx_wren) p0 = ~p0;
      if (z_s1_tx_rdy && s1_tx_wren) p1 = ~p1;
    end
    total++; if (z_tx_clk !== clk) begin bad++; $display("FAIL gap0_txclk got=%b want=%b", z_tx_clk, clk); end
  endtask

`ifdef TX_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    do_reset();
    s0_req = 1; s0_tx_wren = 1; s0_tx_sop = 1; s0_tx_data = 8'h55;
    @(negedge clk); #1;
    total++; if (grant !== 2'b01 || tx_wren !== 1'b1) begin bad++; $display("FAIL wdog_sop got=%b/%b want=01/1", grant, tx_wren); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s0_tx_wren = 0; s0_tx_sop = 0;
      if (i == 7) tx_rdy = 0;
      #1;
      total++; if (grant !== 2'b01 || wdog_abort !== 1'b0 || tx_wren !== 1'b0) begin bad++; $display("FAIL wdog_stall%0d got=%b/%b/%b want=01/0/0", i, grant, wdog_abort, tx_wren); end
    end
    @(negedge clk); #1;
    total++; if ({tx_wren, tx_eop, tx_err, wdog_abort} !== 4'b1111 || tx_data !== 8'h00) begin bad++; $display("FAIL wdog_abort got=%b%b%b%b/%h want=1111/00", tx_wren, tx_eop, tx_err, wdog_abort, tx_data); end
    total++; if (grant !== 2'b00 || s0_tx_rdy !== 1'b0) begin bad++; $display("FAIL wdog_abort_grant got=%b/%b want=00/0", grant, s0_tx_rdy); end
    @(negedge clk);
    s0_req = 0; tx_rdy = 1;
    #1;
    total++; if ({tx_wren, tx_eop, tx_err, wdog_abort} !== 4'b1111) begin bad++; $display("FAIL wdog_hold got=%b%b%b%b want=1111", tx_wren, tx_eop, tx_err, wdog_abort); end
    @(negedge clk); #1;
    total++; if (wdog_abort !== 1'b0 || tx_wren !== 1'b0 || grant !== 2'b00) begin bad++; $display("FAIL wdog_after got=%b/%b/%b want=0/0/00", wdog_abort, tx_wren, grant); end
  endtask
`else
  task automatic test_watchdog();
    do_reset();
    s0_req = 1; s0_tx_wren = 1; s0_tx_sop = 1; s0_tx_data = 8'h55;
    @(negedge clk); #1;
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL nowdog_sop got=%b want=01", grant); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      s0_tx_wren = 0; s0_tx_sop = 0;
      #1;
      total++; if (grant !== 2'b01 || wdog_abort !== 1'b0 || tx_wren !== 1'b0) begin bad++; $display("FAIL nowdog_stall%0d got=%b/%b/%b want=01/0/0", i, grant, wdog_abort, tx_wren); end
    end
    @(negedge clk);
    s0_tx_wren = 1; s0_tx_eop = 1; s0_tx_data = 8'h56;
    #1;
    total++; if (tx_eop !== 1'b1 || tx_data !== 8'h56) begin bad++; $display("FAIL nowdog_eop got=%b/%h want=1/56", tx_eop, tx_data); end
    @(negedge clk);
    s0_req = 0; s0_tx_wren = 0; s0_tx_eop = 0;
    #1;
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL nowdog_release got=%b want=00", grant); end
  endtask
`endif

  task automatic test_rst_mid();
    int waited;
    waited = 0;
    do_reset();
    s0_req = 1; s0_tx_wren = 1; s0_tx_sop = 1; s0_tx_eop = 1; s0_tx_data = 8'h11;
    @(negedge clk); #1;
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL rstmid_s0 got=%b want=01", grant); end
    @(negedge clk);
    s0_req = 0; s0_tx_wren = 0; s0_tx_sop = 0; s0_tx_eop = 0;
    s1_req = 1; s1_tx_wren = 1; s1_tx_sop = 1; s1_tx_data = 8'h77;
    #1;
    while (grant !== 2'b10 && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    total++; if (grant !== 2'b10) begin bad++; $display("FAIL rstmid_wait got=%b want=10", grant); end
    @(negedge clk);
    s1_tx_sop = 0; s1_tx_data = 8'h78;
    @(negedge clk);
    rst = 1; s0_req = 1; s0_tx_wren = 1; s0_tx_sop = 1; s0_tx_data = 8'h22;
    @(negedge clk);
    rst = 0;
    #1;
    total++; if (grant !== 2'b00 || tx_wren !== 1'b0 || s1_tx_rdy !== 1'b0) begin bad++; $display("FAIL rstmid_drop got=%b/%b/%b want=00/0/0", grant, tx_wren, s1_tx_rdy); end
    @(negedge clk); #1;
    total++; if (grant !== 2'b01 || tx_data !== 8'h22) begin bad++; $display("FAIL rstmid_tie got=%b/%h want=01/22", grant, tx_data); end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_tie();
    test_stream64();
    test_drop_req();
    test_gap0();
    test_watchdog();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
